// File: rtl/jtdd_snd_cmd.sv
// jtdd_snd_cmd
// Sound-CPU-side receiver for the main CPU command channel. Each strobe
// of snd_irq pushes one command byte into a small FIFO. The sound CPU
// reads the oldest byte on latch_dout and pops it when its latch read
// ends. While commands are pending, the sound CPU interrupt is held low.
// The reset-enable bit from the main CPU is stretched into the sound CPU
// reset.
//
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   snd_latch   command byte from the main CPU
//   snd_irq     main-side latch strobe (several clk wide, one push per strobe)
//   snd_rstb    main-side sound enable, 0 holds the sound CPU in reset
//   latch_cs    sound CPU read strobe of the latch address (level)
//   latch_dout  oldest queued command byte (holds last byte when empty)
//   snd_irqn    active-low interrupt, asserted while commands are pending
//   snd_rstn    active-low stretched reset to the sound CPU
//   ovf         sticky overflow flag
//   level       number of queued entries
module jtdd_snd_cmd #(
    parameter int DW     = 2,
    parameter int RSTLEN = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    snd_latch,
    input  logic          snd_irq,
    input  logic          snd_rstb,
    input  logic          latch_cs,
    output logic [7:0]    latch_dout,
    output logic          snd_irqn,
    output logic          snd_rstn,
    output logic          ovf,
    output logic [DW:0]   level
);
    localparam int          DEPTH    = 2**DW;
    localparam int          CW       = $clog2(RSTLEN + 1);
    localparam logic [DW:0] FULL_LVL = (DW+1)'(DEPTH);
    localparam logic [CW-1:0] RST_LOAD = CW'(RSTLEN);

    logic [7:0]    mem [DEPTH];
    logic [DW-1:0] wr_ptr, rd_ptr;
    logic          irq_prev, cs_prev;
    logic [CW-1:0] cnt;

    logic          push, pop, full, ovwr;
    logic [DW-1:0] wr_idx, wr_ptr_nx, rd_ptr_nx;
    logic [DW:0]   level_nx;
    logic [7:0]    head_nx;

    // Edge detection and next-state computation for the FIFO
    always_comb begin
        push      = snd_irq & ~irq_prev & snd_rstb;
        // Popping on the falling edge keeps latch_dout stable for the whole
        // CPU access; a pop on an empty FIFO is simply not a pop.
        pop       = cs_prev & ~latch_cs & (level != '0);
        full      = (level == FULL_LVL);
        // Full with no room freed: the newest entry is replaced so that
        // the latest command always reaches the sound CPU.
        ovwr      = push & full & ~pop;
        wr_idx    = ovwr ? (wr_ptr - 1'b1) : wr_ptr;
        wr_ptr_nx = (push & ~ovwr) ? (wr_ptr + 1'b1) : wr_ptr;
        rd_ptr_nx = pop ? (rd_ptr + 1'b1) : rd_ptr;
        level_nx  = level;
        if (push & ~pop & ~full)
            level_nx = level + 1'b1;
        else if (pop & ~push)
            level_nx = level - 1'b1;
        // The new head may be the byte being written on this same cycle.
        head_nx   = (push && (wr_idx == rd_ptr_nx)) ? snd_latch : mem[rd_ptr_nx];
    end

    // Storage: data only, no reset needed
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_idx] <= snd_latch;
    end

    // Control state, output registers and reset stretcher
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            latch_dout <= 8'h00;
            snd_irqn   <= 1'b1;
            ovf        <= 1'b0;
            snd_rstn   <= 1'b0;
            cnt        <= RST_LOAD;
            irq_prev   <= 1'b0;
            cs_prev    <= 1'b0;
        end else begin
            irq_prev <= snd_irq;
            cs_prev  <= latch_cs;
            if (!snd_rstb) begin
                // Sound CPU held in reset: flush the queue, restart stretch.
                // latch_dout keeps its last value.
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                level    <= '0;
                snd_irqn <= 1'b1;
                ovf      <= 1'b0;
                snd_rstn <= 1'b0;
                cnt      <= RST_LOAD;
            end else begin
                wr_ptr   <= wr_ptr_nx;
                rd_ptr   <= rd_ptr_nx;
                level    <= level_nx;
                snd_irqn <= (level_nx == '0);
                if (ovwr)
                    ovf <= 1'b1;
                if (level_nx != '0)
                    latch_dout <= head_nx;
                // Pushes are already accepted here, before snd_rstn rises,
                // so the boot command is kept.
                if (cnt != '0)
                    cnt <= cnt - 1'b1;
                snd_rstn <= (cnt == '0);
            end
        end
    end
endmodule

// File: doc/jtdd_snd_cmd.md
Name: jtdd_snd_cmd

Overview:
Sound-CPU-side receiver for the command channel driven by the main CPU: sound latch byte, latch strobe, and sound reset enable.
- Queues incoming command bytes in a small FIFO and presents the oldest byte to the sound CPU data bus.
- Holds the sound CPU interrupt low while commands are pending.
- Drives a stretched active-low reset to the sound CPU from the main CPU's reset-enable bit.
- Sits between jtdd_main outputs and the sound CPU/decoder in the sound subsystem.

Parameters:
DW, 2, log2 of FIFO depth (depth = 2**DW = 4 entries)
RSTLEN, 16, clk cycles snd_rstn stays low after snd_rstb rises

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
snd_latch  input  8  command byte from main CPU
snd_irq  input  1  main-side latch strobe, high for one main cen_Q period (several clk cycles)
snd_rstb  input  1  main-side sound enable; 0 = hold sound CPU in reset
latch_cs  input  1  sound CPU read strobe of latch address (chip select & RnW), level
latch_dout  output  8  oldest queued command byte
snd_irqn  output  1  active-low interrupt to sound CPU
snd_rstn  output  1  active-low reset to sound CPU
ovf  output  1  sticky overflow flag
level  output  DW+1  number of queued entries (0..2**DW)

Behaviour:
Reset (rst=1 at posedge clk):
- FIFO emptied, level=0, latch_dout=8'h00, snd_irqn=1, ovf=0, snd_rstn=0.
- RSTLEN counter loaded with RSTLEN.
- Edge-detector history regs cleared to 0.

Push:
- Rising edge of snd_irq, detected in clk domain (registered previous value; push when snd_irq & ~prev).
- Exactly one push per strobe, regardless of strobe width.
- Data = snd_latch sampled on the detection cycle.
- Full and no pop on the same cycle: newest entry overwritten with new byte, level unchanged, ovf set. Single-latch semantics: latest command always wins.

Pop:
- Falling edge of latch_cs (latch_cs prev=1, now=0), so latch_dout stays stable during the whole CPU access.
- Pop while empty: ignored, no state change.

Simultaneous push and pop on one cycle:
- Both performed, level unchanged, no overflow even when full.
- Push into empty FIFO with a coincident (ignored) pop: level=1.

Outputs:
- latch_dout: registered; equals head entry when level>0. When empty it holds the last value presented (last popped byte), never 8'hff.
- Head update latency: one clk after the push/pop detection cycle.
- snd_irqn = ~(level!=0), registered, updates same cycle as level.
- ovf: cleared only by rst or by flush.

Sound reset:
- snd_rstb=0: snd_rstn=0 next cycle, counter reloaded to RSTLEN, FIFO flushed (level=0, ovf=0, pointers 0). Pushes while snd_rstb=0 are discarded.
- snd_rstb=1: counter decrements each clk. snd_rstn goes 1 on the cycle after counter reaches 0, i.e. exactly RSTLEN+1 clk after the first sampled snd_rstb=1.
- Pushes are accepted once snd_rstb=1, even while snd_rstn is still 0, so the boot command is not lost.
- snd_rstb dropping mid-stretch restarts the stretch from RSTLEN.

Pointers:
- Read/write pointers are DW bits and wrap modulo 2**DW.
- level is DW+1 bits, never exceeds 2**DW.

Test Plan:
- Reset release with snd_rstb=0, then snd_rstb=1 at cycle T -> snd_rstn=0 through T+16, snd_rstn=1 at T+17; snd_irqn=1, level=0, latch_dout=00 throughout.
- One snd_irq strobe 8 clk wide, snd_latch=8'h3C -> exactly one push: level=1, snd_irqn=0, latch_dout=3C; latch_cs 4-clk pulse then low -> level=0, snd_irqn=1, latch_dout holds 3C.
- Push 11,22,33,44,55 with no reads -> level=4, ovf=1; four reads return 11,22,33,55 in order; fifth read ignored, level=0.
- FIFO full (A1..A4) with push B0 and latch_cs falling edge on the same cycle -> level stays 4, ovf=0, reads return A2,A3,A4,B0.
- Two entries queued, snd_rstb=0 for 3 cycles with a push during it -> level=0, ovf=0, snd_irqn=1, snd_rstn=0, push discarded; reset stretch restarts on snd_rstb=1.
- 10 push/pop cycles crossing pointer wrap with bytes 00..09 -> bytes read in order 00..09, level never exceeds 4, ovf=0.
